// File: rtl/tv80_bus_model.sv
//------------------------------------------------------------------------------
// Module      : tv80_bus_model
// Description : TV80 CPU bus responder with wait-state insertion, memory/IO
//               arrays and a write-log FIFO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tv80_bus_model #(
    parameter int ADDR_W    = 16,
    parameter int IO_ADDR_W = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int M1_WAIT   = 0,
    parameter int LOG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  cpu_do,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    input  logic        log_pop,
    output logic        log_valid,
    output logic        log_io,
    output logic [15:0] log_addr,
    output logic [7:0]  log_data,
    output logic        log_overflow,
    output logic [15:0] wr_count
);

    localparam int               c_PTR_W    = $clog2(LOG_DEPTH);
    localparam logic [15:0]      c_LOAD_IO  = 16'(IO_WAIT);
    localparam logic [15:0]      c_LOAD_M1  = 16'(MEM_WAIT + M1_WAIT);
    localparam logic [15:0]      c_LOAD_MEM = 16'(MEM_WAIT);
    localparam logic [c_PTR_W:0]   c_OCC_FULL = (c_PTR_W + 1)'(LOG_DEPTH);
    localparam logic [c_PTR_W:0]   c_OCC_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_wr_done, w_wr_done_nxt;
    logic        w_wr_fire;
    logic        w_strobe;
    logic        w_is_io;
    logic [15:0] w_load;

    logic [7:0]  r_mem [0:2**ADDR_W-1];
    logic [7:0]  r_io  [0:2**IO_ADDR_W-1];
    logic [7:0]  r_cpu_di;

    logic [24:0]        r_fifo [0:LOG_DEPTH-1];
    logic [c_PTR_W-1:0] r_wptr, r_rptr;
    logic [c_PTR_W:0]   r_occ;
    logic               r_overflow;
    logic [15:0]        r_wr_count;
    logic               w_pop, w_push_ok, w_full;
    logic [24:0]        w_head;
    logic               w_unused_ok;

    // Refresh and interrupt-acknowledge cycles never qualify as accesses.
    assign w_strobe    = (!mreq_n && rfsh_n) || (!iorq_n && m1_n);
    assign w_is_io     = !iorq_n;
    assign w_load      = w_is_io ? c_LOAD_IO : (!m1_n ? c_LOAD_M1 : c_LOAD_MEM);
    assign w_unused_ok = rd_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_wr_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_done <= w_wr_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wr_done_nxt = r_wr_done;
        w_wr_fire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_done_nxt = 1'b0;
                if (w_strobe) begin
                    if (w_load != 16'd0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = w_load;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_WAIT: begin
                // Counter holds the remaining low cycles including this one.
                if (!w_strobe) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= 16'd1) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (!w_strobe) begin
                    w_state_nxt = ST_IDLE;
                end else if (!wr_n && !r_wr_done) begin
                    w_wr_fire     = 1'b1;
                    w_wr_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wait_n = (r_state != ST_WAIT);

    // Storage arrays are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            if (w_is_io) begin
                r_io[a[IO_ADDR_W-1:0]] <= cpu_do;
            end else begin
                r_mem[a[ADDR_W-1:0]] <= cpu_do;
            end
        end
        if (w_push_ok) begin
            r_fifo[r_wptr] <= {w_is_io, a, cpu_do};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_di <= 8'h00;
        end else begin
            r_cpu_di <= w_is_io ? r_io[a[IO_ADDR_W-1:0]] : r_mem[a[ADDR_W-1:0]];
        end
    end

    assign cpu_di = r_cpu_di;

    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_full    = (r_occ == c_OCC_FULL);
    assign w_pop     = log_pop && (r_occ != '0);
    assign w_push_ok = w_wr_fire && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
            r_wr_count <= 16'd0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_ONE;
                2'b01:   r_occ <= r_occ - c_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
            if (w_wr_fire && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_fire && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign w_head       = r_fifo[r_rptr];
    assign log_valid    = (r_occ != '0);
    assign log_io       = log_valid & w_head[24];
    assign log_addr     = log_valid ? w_head[23:8] : 16'h0000;
    assign log_data     = log_valid ? w_head[7:0]  : 8'h00;
    assign log_overflow = r_overflow;
    assign wr_count     = r_wr_count;

endmodule

`default_nettype wire

// File: doc/tv80_bus_model.md
TV80_BUS_MODEL -- requirements
Module: tv80_bus_model

Interface
REQ-001 Parameter ADDR_W, default 16: memory address width; memory depth is 2**ADDR_W bytes.
REQ-002 Parameter IO_ADDR_W, default 8: I/O address width; I/O depth is 2**IO_ADDR_W bytes.
REQ-003 Parameter MEM_WAIT, default 0: wait cycles inserted per memory access.
REQ-004 Parameter IO_WAIT, default 1: wait cycles inserted per I/O access.
REQ-005 Parameter M1_WAIT, default 0: extra wait cycles added to opcode-fetch (M1) memory accesses.
REQ-006 Parameter LOG_DEPTH, default 8, power of two: write-log FIFO depth.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 a  in  16  CPU address bus.
REQ-010 cpu_do  in  8  CPU write data.
REQ-011 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes, active-low.
REQ-012 cpu_di  out  8  read data to CPU.
REQ-013 wait_n  out  1  wait request to CPU, active-low.
REQ-014 log_pop  in  1  bench pops the FIFO head.
REQ-015 log_valid  out  1  FIFO not empty.
REQ-016 log_io, log_addr[15:0], log_data[7:0]  out  FIFO head entry: I/O flag, address, data.
REQ-017 log_overflow  out  1  sticky flag: a write was dropped.
REQ-018 wr_count  out  16  number of performed writes.

Function
REQ-019 The access strobe SHALL be (mreq_n=0 and rfsh_n=1) or (iorq_n=0 and m1_n=1); refresh and interrupt-acknowledge cycles SHALL never wait, write or log.
REQ-020 The FSM SHALL have states IDLE, WAIT and ACTIVE. IDLE->WAIT occurs on the first clk with the strobe asserted and a non-zero load value; IDLE->ACTIVE occurs when the load value is 0. WAIT->ACTIVE occurs when the counter reaches 0. ACTIVE->IDLE occurs on the first clk with the strobe deasserted.
REQ-021 The wait counter SHALL load IO_WAIT for I/O accesses, or MEM_WAIT+M1_WAIT when m1_n=0 and MEM_WAIT otherwise; it decrements once per clk in WAIT.
REQ-022 wait_n SHALL be 0 exactly while in WAIT, giving precisely N low cycles for a load value N, starting the cycle after the strobe is detected.
REQ-023 cpu_di SHALL be registered every clk: io[a[IO_ADDR_W-1:0]] when iorq_n=0, else mem[a[ADDR_W-1:0]]; latency is 1 clk.
REQ-024 Address bits above ADDR_W or IO_ADDR_W SHALL be ignored, so the address space wraps (aliases).
REQ-025 A write SHALL be performed once per access, on the first ACTIVE clk with wr_n=0; later cycles of the same access SHALL NOT rewrite, count or log.
REQ-026 Each performed write SHALL push {io, a, cpu_do} into the log FIFO and increment wr_count, which saturates at FFFF.
REQ-027 A pop SHALL occur when log_pop=1 and log_valid=1; log_pop while empty SHALL be ignored.
REQ-028 A simultaneous push and pop while full SHALL succeed with no loss and no overflow; the occupancy is unchanged.
REQ-029 A push while full without a pop SHALL drop the entry and set log_overflow, which stays set until reset.
REQ-030 Memory and I/O arrays SHALL NOT be reset; the bench preloads them hierarchically.

Reset
REQ-031 While reset=1, the outputs SHALL be: wait_n=1, cpu_di=00, log_valid=0, log_io=0, log_addr=0000, log_data=00, log_overflow=0, wr_count=0000; the FSM SHALL be in IDLE and the FIFO empty.
REQ-032 Reset asserted mid-access SHALL release wait_n immediately (asynchronously), abort the access without a write, and preserve memory contents.

Verification
REQ-033 Preload mem[0000]=AF with MEM_WAIT=0 and run an M1 fetch at 0000 -> cpu_di=AF one clk after the address is stable, and wait_n stays 1 throughout.
REQ-034 With IO_WAIT=2, run OUT (12),5A -> wait_n is low for exactly 2 clks, io[12]=5A, and the log head is {1,0012,5A}.
REQ-035 Hold a memory write at DCA6 with data 49 for 3 clks -> mem[DCA6]=49, wr_count=1, and exactly one log entry.
REQ-036 With LOG_DEPTH=8, issue 9 writes with no pop -> log_overflow=1 and the FIFO holds the first 8 entries; a further push+pop while full -> occupancy stays 8 and the head advances.
REQ-037 Assert reset during WAIT (IO_WAIT=3) -> wait_n=1 at once, no write occurs, log_valid=0, and preloaded memory is intact.
REQ-038 Run a refresh cycle (mreq_n=0, rfsh_n=0) -> wait_n stays 1, no log entry, and wr_count is unchanged.
